// File: rtl/scalar_mult_ctrl_if.sv
// Core-side bundle between the scalar-multiply sequencer and its point adder/doubler.
interface scalar_mult_ctrl_if #(
    parameter int unsigned W = 256
);
    logic         add_start;
    logic [W-1:0] add_px, add_py, add_pz;
    logic [W-1:0] add_qx, add_qy, add_qz;
    logic [W-1:0] add_rx, add_ry, add_rz;
    logic         add_ready;
    logic         dbl_start;
    logic [W-1:0] dbl_x, dbl_y, dbl_z;
    logic [W-1:0] dbl_rx, dbl_ry, dbl_rz;
    logic         dbl_ready;

    modport master (
        output add_start, add_px, add_py, add_pz, add_qx, add_qy, add_qz,
        input  add_rx, add_ry, add_rz, add_ready,
        output dbl_start, dbl_x, dbl_y, dbl_z,
        input  dbl_rx, dbl_ry, dbl_rz, dbl_ready
    );

    modport slave (
        input  add_start, add_px, add_py, add_pz, add_qx, add_qy, add_qz,
        output add_rx, add_ry, add_rz, add_ready,
        input  dbl_start, dbl_x, dbl_y, dbl_z,
        output dbl_rx, dbl_ry, dbl_rz, dbl_ready
    );
endinterface

// File: rtl/scalar_mult_ctrl.sv
// Left-to-right double-and-add sequencer for Jacobian R = k*P; drives external
// point adder/doubler cores and tracks the accumulator and its infinity flag.
module scalar_mult_ctrl #(
    parameter int unsigned W       = 256,
    parameter int unsigned N       = 256,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [N-1:0]       k,
    input  logic [W-1:0]       px,
    input  logic [W-1:0]       py,
    input  logic [W-1:0]       pz,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [W-1:0]       rx,
    output logic [W-1:0]       ry,
    output logic [W-1:0]       rz,
    output logic               r_inf,
    scalar_mult_ctrl_if.master cif
);
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    localparam logic [3:0] IDLE     = 4'd0;
    localparam logic [3:0] STEP     = 4'd1;
    localparam logic [3:0] DBL_GO   = 4'd2;
    localparam logic [3:0] DBL_WAIT = 4'd3;
    localparam logic [3:0] LOAD     = 4'd4;
    localparam logic [3:0] ADD_GO   = 4'd5;
    localparam logic [3:0] ADD_WAIT = 4'd6;
    localparam logic [3:0] NEXT     = 4'd7;
    localparam logic [3:0] FIN      = 4'd8;

    logic [3:0]    state, state_d;
    logic [IW-1:0] idx, idx_d;
    logic [CW-1:0] wcnt, wcnt_d;
    logic [N-1:0]  k_q, k_d;
    logic [W-1:0]  bx, by, bz, bx_d, by_d, bz_d;
    logic [W-1:0]  ax, ay, az, ax_d, ay_d, az_d;
    logic          acc_inf, acc_inf_d;
    logic [W-1:0]  rx_d, ry_d, rz_d;
    logic          r_inf_d, busy_d, done_d, err_d;
    logic          add_start_q, add_start_d, dbl_start_q, dbl_start_d;
    logic          bit_set, armed, tmo;

    assign bit_set = k_q[idx];
    // Ready from the previous op may still be high in the first wait cycle.
    assign armed   = (wcnt != '0);
    assign tmo     = (wcnt == CW'(TIMEOUT - 1));

    always_comb begin
        state_d   = state;
        idx_d     = idx;
        wcnt_d    = wcnt;
        k_d       = k_q;
        bx_d      = bx;
        by_d      = by;
        bz_d      = bz;
        ax_d      = ax;
        ay_d      = ay;
        az_d      = az;
        acc_inf_d = acc_inf;
        rx_d      = rx;
        ry_d      = ry;
        rz_d      = rz;
        r_inf_d   = r_inf;
        err_d     = err;
        case (state)
            IDLE: begin
                if (start) begin
                    k_d       = k;
                    bx_d      = px;
                    by_d      = py;
                    bz_d      = pz;
                    idx_d     = IW'(N - 1);
                    acc_inf_d = 1'b1;
                    err_d     = 1'b0;
                    state_d   = STEP;
                end
            end
            STEP: begin
                if (!acc_inf)     state_d = DBL_GO;
                else if (bit_set) state_d = LOAD;
                else              state_d = NEXT;
            end
            DBL_GO: begin
                wcnt_d  = '0;
                state_d = DBL_WAIT;
            end
            DBL_WAIT: begin
                if (armed && cif.dbl_ready) begin
                    ax_d      = cif.dbl_rx;
                    ay_d      = cif.dbl_ry;
                    az_d      = cif.dbl_rz;
                    acc_inf_d = (cif.dbl_rz == '0);
                    if (!bit_set)                state_d = NEXT;
                    else if (cif.dbl_rz == '0)   state_d = LOAD;
                    else                         state_d = ADD_GO;
                end else if (tmo) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    wcnt_d = wcnt + CW'(1);
                end
            end
            LOAD: begin
                ax_d      = bx;
                ay_d      = by;
                az_d      = bz;
                acc_inf_d = (bz == '0);
                state_d   = NEXT;
            end
            ADD_GO: begin
                wcnt_d  = '0;
                state_d = ADD_WAIT;
            end
            ADD_WAIT: begin
                // z == 0 also catches the acc == -P cancellation.
                if (armed && cif.add_ready) begin
                    ax_d      = cif.add_rx;
                    ay_d      = cif.add_ry;
                    az_d      = cif.add_rz;
                    acc_inf_d = (cif.add_rz == '0);
                    state_d   = NEXT;
                end else if (tmo) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    wcnt_d = wcnt + CW'(1);
                end
            end
            NEXT: begin
                if (idx == '0) begin
                    rx_d    = acc_inf ? W'(1) : ax;
                    ry_d    = acc_inf ? W'(1) : ay;
                    rz_d    = acc_inf ? '0    : az;
                    r_inf_d = acc_inf;
                    state_d = FIN;
                end else begin
                    idx_d   = idx - IW'(1);
                    state_d = STEP;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d      = (state_d != IDLE) && (state_d != FIN);
        done_d      = (state_d == FIN);
        dbl_start_d = (state_d == DBL_GO);
        add_start_d = (state_d == ADD_GO);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            wcnt        <= '0;
            k_q         <= '0;
            bx          <= '0;
            by          <= '0;
            bz          <= '0;
            ax          <= '0;
            ay          <= '0;
            az          <= '0;
            acc_inf     <= 1'b1;
            rx          <= '0;
            ry          <= '0;
            rz          <= '0;
            r_inf       <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            add_start_q <= 1'b0;
            dbl_start_q <= 1'b0;
        end else begin
            state       <= state_d;
            idx         <= idx_d;
            wcnt        <= wcnt_d;
            k_q         <= k_d;
            bx          <= bx_d;
            by          <= by_d;
            bz          <= bz_d;
            ax          <= ax_d;
            ay          <= ay_d;
            az          <= az_d;
            acc_inf     <= acc_inf_d;
            rx          <= rx_d;
            ry          <= ry_d;
            rz          <= rz_d;
            r_inf       <= r_inf_d;
            busy        <= busy_d;
            done        <= done_d;
            err         <= err_d;
            add_start_q <= add_start_d;
            dbl_start_q <= dbl_start_d;
        end
    end

    // Accumulator feeds the doubler and the adder P side; captured base is the Q side.
    assign cif.dbl_start = dbl_start_q;
    assign cif.dbl_x     = ax;
    assign cif.dbl_y     = ay;
    assign cif.dbl_z     = az;
    assign cif.add_start = add_start_q;
    assign cif.add_px    = ax;
    assign cif.add_py    = ay;
    assign cif.add_pz    = az;
    assign cif.add_qx    = bx;
    assign cif.add_qy    = by;
    assign cif.add_qz    = bz;
endmodule

// File: tb/tb_scalar_mult_ctrl.sv
// Bench for scalar_mult_ctrl: stub cores with fixed latency and stale ready,
// a vector table of scalars, plus timeout, busy-start, FIN-start and reset sequences.
module tb_scalar_mult_ctrl;
    localparam int unsigned W       = 256;
    localparam int unsigned N       = 256;
    localparam int unsigned TIMEOUT = 16;
    localparam int          LAT     = 7;

    typedef struct packed {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] z;
    } pt_t;

    typedef struct {
        logic [N-1:0] k;
        bit           zfirst;
        bit           pzero;
        pt_t          res;
        bit           inf;
        int           ndbl;
        int           nadd;
        int           ncyc;
    } vec_t;

    logic         clk   = 1'b0;
    logic         rst   = 1'b1;
    logic         start = 1'b0;
    logic [N-1:0] k     = '0;
    logic [W-1:0] px    = '0;
    logic [W-1:0] py    = '0;
    logic [W-1:0] pz    = '0;
    logic         busy, done, err, r_inf;
    logic [W-1:0] rx, ry, rz;

    scalar_mult_ctrl_if #(.W(W)) cif ();

    scalar_mult_ctrl #(.W(W), .N(N), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .start(start), .k(k),
        .px(px), .py(py), .pz(pz),
        .busy(busy), .done(done), .err(err),
        .rx(rx), .ry(ry), .rz(rz), .r_inf(r_inf),
        .cif(cif)
    );

    always #5 clk = ~clk;

    int  checks = 0;
    int  failures = 0;
    bit  never_mode = 1'b0;
    bit  zfirst_mode = 1'b0;
    int  dcalls_base = 0;
    pt_t cur_p = '0;
    pt_t p_base, p_zero;
    vec_t vt [8];

    // Arbitrary invertible-looking stand-ins for the point formulas.
    function automatic pt_t dbl_fn(input pt_t a, input bit zero);
        pt_t r;
        r.x = a.x + a.y + W'(1);
        r.y = a.y ^ (a.x << 1);
        r.z = zero ? '0 : a.z + W'(2);
        return r;
    endfunction

    function automatic pt_t add_fn(input pt_t p, input pt_t q);
        pt_t r;
        r.x = p.x + (q.x ^ W'(1));
        r.y = p.y - q.y;
        r.z = p.z + (q.z << 1);
        return r;
    endfunction

    // Doubler stub: ready stays high from the previous op until the edge after a start.
    int  dcnt = 0, dcalls = 0, dop_bad = 0;
    logic drdy = 1'b0;
    pt_t dop = '0, dres = '0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            dcnt <= 0;
            drdy <= 1'b0;
        end else if (cif.dbl_start) begin
            dcnt <= LAT - 1;
            dop  <= {cif.dbl_x, cif.dbl_y, cif.dbl_z};
            if (dcalls == dcalls_base && {cif.dbl_x, cif.dbl_y, cif.dbl_z} !== cur_p)
                dop_bad <= dop_bad + 1;
            dcalls <= dcalls + 1;
        end else if (dcnt > 1) begin
            dcnt <= dcnt - 1;
            drdy <= 1'b0;
        end else if (dcnt == 1) begin
            dcnt <= 0;
            if (!never_mode) begin
                drdy <= 1'b1;
                dres <= dbl_fn(dop, zfirst_mode && (dcalls == dcalls_base + 1));
            end
        end
    end

    int  acnt = 0, acalls = 0, aop_bad = 0;
    logic ardy = 1'b0;
    pt_t aop_p = '0, aop_q = '0, ares = '0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            acnt <= 0;
            ardy <= 1'b0;
        end else if (cif.add_start) begin
            acnt  <= LAT - 1;
            aop_p <= {cif.add_px, cif.add_py, cif.add_pz};
            aop_q <= {cif.add_qx, cif.add_qy, cif.add_qz};
            if ({cif.add_px, cif.add_py, cif.add_pz} !== dres ||
                {cif.add_qx, cif.add_qy, cif.add_qz} !== cur_p)
                aop_bad <= aop_bad + 1;
            acalls <= acalls + 1;
        end else if (acnt > 1) begin
            acnt <= acnt - 1;
            ardy <= 1'b0;
        end else if (acnt == 1) begin
            acnt <= 0;
            ardy <= 1'b1;
            ares <= add_fn(aop_p, aop_q);
        end
    end

    int stab_bad = 0;
    always @(negedge clk) begin
        if (dcnt != 0 && {cif.dbl_x, cif.dbl_y, cif.dbl_z} !== dop)
            stab_bad <= stab_bad + 1;
        if (acnt != 0 && ({cif.add_px, cif.add_py, cif.add_pz} !== aop_p ||
                          {cif.add_qx, cif.add_qy, cif.add_qz} !== aop_q))
            stab_bad <= stab_bad + 1;
    end

    assign cif.dbl_rx    = dres.x;
    assign cif.dbl_ry    = dres.y;
    assign cif.dbl_rz    = dres.z;
    assign cif.dbl_ready = drdy;
    assign cif.add_rx    = ares.x;
    assign cif.add_ry    = ares.y;
    assign cif.add_rz    = ares.z;
    assign cif.add_ready = ardy;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic wait_done(input string name, input int limit, output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < limit) begin
            @(negedge clk);
            cyc++;
        end
        chk({name, "_done_seen"}, W'(done), W'(1));
    endtask

    task automatic drive(input logic [N-1:0] kv, input pt_t p);
        k  = kv;
        px = p.x;
        py = p.y;
        pz = p.z;
    endtask

    task automatic run_vec(input int id, input vec_t v);
        pt_t p;
        int cyc, d0, a0, s0, o0, q0;
        bit got;
        string t;
        t = $sformatf("v%0d", id);
        p = v.pzero ? p_zero : p_base;
        cur_p = p;
        zfirst_mode = v.zfirst;
        dcalls_base = dcalls;
        d0 = dcalls; a0 = acalls; s0 = stab_bad; o0 = dop_bad; q0 = aop_bad;
        drive(v.k, p);
        start = 1'b1;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                start = 1'b0;
                chk({t, "_busy_after_accept"}, W'(busy), W'(1));
                chk({t, "_err_cleared"}, W'(err), W'(0));
            end
            got = (done === 1'b1);
        end
        chk({t, "_done_seen"}, W'(got), W'(1));
        if (v.ncyc != 0) chk({t, "_cycles"}, W'(cyc), W'(v.ncyc));
        chk({t, "_rx"}, rx, v.res.x);
        chk({t, "_ry"}, ry, v.res.y);
        chk({t, "_rz"}, rz, v.res.z);
        chk({t, "_r_inf"}, W'(r_inf), W'(v.inf));
        chk({t, "_busy_at_done"}, W'(busy), W'(0));
        chk({t, "_dbl_starts"}, W'(dcalls - d0), W'(v.ndbl));
        chk({t, "_add_starts"}, W'(acalls - a0), W'(v.nadd));
        chk({t, "_operand_stable"}, W'(stab_bad - s0), W'(0));
        chk({t, "_operand_values"}, W'((dop_bad - o0) + (aop_bad - q0)), W'(0));
        @(negedge clk);
        chk({t, "_done_one_cycle"}, W'(done), W'(0));
    endtask

    initial begin
        int n, cyc, d0, a0;
        bit seen_done;
        pt_t t;

        p_base.x = 256'hfed5b7e8_3a4c5d6e_7f801122_33445566_778899aa_bbccddee_ff001234_5678219a;
        p_base.y = 256'h51898bfd_0badc0de_12345678_9abcdef0_0fedcba9_87654321_deadbeef_cafe0ca6;
        p_base.z = W'(1);
        p_zero   = p_base;
        p_zero.z = '0;

        vt[0] = '{k: '0, zfirst: 0, pzero: 0, res: {W'(1), W'(1), W'(0)}, inf: 1,
                  ndbl: 0, nadd: 0, ncyc: 2 * N + 1};
        vt[1] = '{k: 256'd1, zfirst: 0, pzero: 0, res: p_base, inf: 0,
                  ndbl: 0, nadd: 0, ncyc: 2 * N + 2};
        vt[2] = '{k: 256'd3, zfirst: 0, pzero: 0, res: add_fn(dbl_fn(p_base, 0), p_base),
                  inf: 0, ndbl: 1, nadd: 1, ncyc: 0};
        vt[3] = '{k: 256'd2, zfirst: 0, pzero: 0, res: dbl_fn(p_base, 0), inf: 0,
                  ndbl: 1, nadd: 0, ncyc: 0};
        vt[4] = '{k: 256'd5, zfirst: 0, pzero: 0,
                  res: add_fn(dbl_fn(dbl_fn(p_base, 0), 0), p_base), inf: 0,
                  ndbl: 2, nadd: 1, ncyc: 0};
        vt[5] = '{k: 256'd3, zfirst: 1, pzero: 0, res: p_base, inf: 0,
                  ndbl: 1, nadd: 0, ncyc: 0};
        vt[6] = '{k: 256'd1, zfirst: 0, pzero: 1, res: {W'(1), W'(1), W'(0)}, inf: 1,
                  ndbl: 0, nadd: 0, ncyc: 0};
        t = p_base;
        for (int i = 0; i < 255; i++) t = dbl_fn(t, 0);
        vt[7] = '{k: {1'b1, 254'd0, 1'b1}, zfirst: 0, pzero: 0, res: add_fn(t, p_base),
                  inf: 0, ndbl: 255, nadd: 1, ncyc: 0};

        repeat (2) @(negedge clk);
        chk("reset_busy", W'(busy), W'(0));
        chk("reset_done", W'(done), W'(0));
        chk("reset_err", W'(err), W'(0));
        chk("reset_rx", rx, W'(0));
        chk("reset_r_inf", W'(r_inf), W'(1));
        chk("reset_dbl_start", W'(cif.dbl_start), W'(0));
        chk("reset_add_start", W'(cif.add_start), W'(0));
        chk("reset_dbl_x", cif.dbl_x, W'(0));
        chk("reset_add_qx", cif.add_qx, W'(0));
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) run_vec(i, vt[i]);

        // Doubler never answers: timeout after 16 wait cycles, previous result kept.
        cur_p = p_base; zfirst_mode = 1'b0; never_mode = 1'b1; dcalls_base = dcalls;
        drive(256'd3, p_base);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (cif.dbl_start !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("tmo_dbl_start_seen", W'(cif.dbl_start), W'(1));
        n = 0;
        seen_done = 1'b0;
        while (err !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
            if (done === 1'b1) seen_done = 1'b1;
        end
        chk("tmo_cycles", W'(n), W'(17));
        chk("tmo_err", W'(err), W'(1));
        chk("tmo_busy", W'(busy), W'(0));
        chk("tmo_no_done", W'(seen_done), W'(0));
        chk("tmo_rx_kept", rx, vt[7].res.x);
        chk("tmo_r_inf_kept", W'(r_inf), W'(0));
        never_mode = 1'b0;
        @(negedge clk);
        run_vec(8, vt[1]);

        // A start while busy must not restart the run.
        cur_p = p_base; dcalls_base = dcalls;
        drive(256'd2, p_base);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        drive(256'd1, p_zero);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("ign", 2000, cyc);
        chk("ign_rx", rx, vt[3].res.x);
        chk("ign_rz", rz, vt[3].res.z);
        chk("ign_r_inf", W'(r_inf), W'(0));
        @(negedge clk);

        // Start raised in the done cycle is taken one cycle later, from IDLE.
        drive(256'd1, p_base);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("fin", 2000, cyc);
        drive('0, p_base);
        start = 1'b1;
        @(negedge clk);
        chk("fin_start_ignored", W'(busy), W'(0));
        chk("fin_done_dropped", W'(done), W'(0));
        @(negedge clk);
        start = 1'b0;
        chk("fin_accept_next", W'(busy), W'(1));
        wait_done("fin2", 2000, cyc);
        chk("fin2_r_inf", W'(r_inf), W'(1));
        chk("fin2_rz", rz, W'(0));
        @(negedge clk);

        // Reset mid-run returns everything to reset values without a clock edge.
        run_vec(9, vt[2]);
        cur_p = p_base; dcalls_base = dcalls;
        drive(vt[7].k, p_base);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (100) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", W'(busy), W'(0));
        chk("arst_done", W'(done), W'(0));
        chk("arst_err", W'(err), W'(0));
        chk("arst_rx", rx, W'(0));
        chk("arst_ry", ry, W'(0));
        chk("arst_r_inf", W'(r_inf), W'(1));
        chk("arst_dbl_start", W'(cif.dbl_start), W'(0));
        chk("arst_add_start", W'(cif.add_start), W'(0));
        chk("arst_dbl_x", cif.dbl_x, W'(0));
        chk("arst_add_qx", cif.add_qx, W'(0));
        @(negedge clk);
        rst = 1'b0;
        d0 = dcalls;
        a0 = acalls;
        repeat (30) @(negedge clk);
        chk("arst_no_core_starts", W'((dcalls - d0) + (acalls - a0)), W'(0));
        chk("arst_idle", W'(busy), W'(0));
        run_vec(10, vt[3]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
